// File: rtl/cpu_pkg.sv
//============================================================================
// Module      : cpu_pkg
// Description : Shared multicycle MIPS constants: FSM states, opcodes,
//               ALUOp codes and datapath mux selects.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

package cpu_pkg;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_MEM_ADDR  = 4'd2,
        ST_MEM_READ  = 4'd3,
        ST_MEM_WB    = 4'd4,
        ST_MEM_WRITE = 4'd5,
        ST_EXECUTE   = 4'd6,
        ST_R_WB      = 4'd7,
        ST_BRANCH    = 4'd8,
        ST_ADDI_EXEC = 4'd9,
        ST_LUI_EXEC  = 4'd10,
        ST_IMM_WB    = 4'd11,
        ST_JUMP      = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_BNE  = 6'h05;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LUI  = 6'h0F;
    localparam logic [5:0] OP_J    = 6'h02;

    localparam logic [1:0] ALUOP_FUNCT = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_ADD   = 2'b10;
    localparam logic [1:0] ALUOP_LUI   = 2'b11;

    localparam logic [1:0] ALUSRCB_REG   = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR  = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM   = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    function automatic logic is_legal_op(input logic [5:0] op);
        return (op == OP_R)   || (op == OP_LW)   || (op == OP_SW)  ||
               (op == OP_BEQ) || (op == OP_BNE)  || (op == OP_ADDI) ||
               (op == OP_LUI) || (op == OP_J);
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control.sv
//============================================================================
// Module      : multicycle_control
// Description : Main control FSM of the multicycle MIPS datapath.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module multicycle_control
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       zero,
    output logic       pc_write,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       illegal
);

    state_t r_state;
    state_t w_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = ST_FETCH;
        case (r_state)
            ST_FETCH:     w_next = ST_DECODE;
            ST_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW:   w_next = ST_MEM_ADDR;
                    OP_R:           w_next = ST_EXECUTE;
                    OP_BEQ, OP_BNE: w_next = ST_BRANCH;
                    OP_ADDI:        w_next = ST_ADDI_EXEC;
                    OP_LUI:         w_next = ST_LUI_EXEC;
                    OP_J:           w_next = ST_JUMP;
                    default:        w_next = ST_FETCH;
                endcase
            end
            ST_MEM_ADDR: begin
                if (opcode == OP_LW) begin
                    w_next = ST_MEM_READ;
                end else if (opcode == OP_SW) begin
                    w_next = ST_MEM_WRITE;
                end else begin
                    w_next = ST_FETCH;
                end
            end
            ST_MEM_READ:  w_next = ST_MEM_WB;
            ST_EXECUTE:   w_next = ST_R_WB;
            ST_ADDI_EXEC: w_next = ST_IMM_WB;
            ST_LUI_EXEC:  w_next = ST_IMM_WB;
            default:      w_next = ST_FETCH;
        endcase
    end

    always_comb begin
        pc_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = ALUSRCB_REG;
        alu_op     = ALUOP_FUNCT;
        pc_source  = PCSRC_ALU;
        illegal    = 1'b0;
        case (r_state)
            ST_FETCH: begin
                mem_read  = 1'b1;
                ir_write  = 1'b1;
                pc_write  = 1'b1;
                alu_src_b = ALUSRCB_FOUR;
                alu_op    = ALUOP_ADD;
            end
            ST_DECODE: begin
                alu_src_b = ALUSRCB_IMMSH;
                alu_op    = ALUOP_ADD;
                illegal   = ~is_legal_op(opcode);
            end
            ST_MEM_ADDR, ST_ADDI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUSRCB_IMM;
                alu_op    = ALUOP_ADD;
            end
            ST_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
            end
            ST_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_MEM_WRITE: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
            end
            ST_EXECUTE: begin
                alu_src_a = 1'b1;
            end
            ST_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALUOP_SUB;
                pc_source = PCSRC_ALUOUT;
                // Only Mealy output: branch decision taken from the live zero flag
                pc_write  = ((opcode == OP_BEQ) &&  zero) ||
                            ((opcode == OP_BNE) && !zero);
            end
            ST_LUI_EXEC: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUSRCB_IMM;
                alu_op    = ALUOP_LUI;
            end
            ST_IMM_WB: begin
                reg_write = 1'b1;
            end
            ST_JUMP: begin
                pc_write  = 1'b1;
                pc_source = PCSRC_JUMP;
            end
            default: begin
            end
        endcase
        // Strobes are masked while reset is held so an abandoned instruction issues nothing
        if (rst) begin
            pc_write  = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            ir_write  = 1'b0;
            reg_write = 1'b0;
            illegal   = 1'b0;
        end
    end

    assign state = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
//============================================================================
// Module      : tb_multicycle_control
// Description : Self-checking bench for multicycle_control.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write;
    logic       reg_dst, mem_to_reg, alu_src_a, illegal;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    multicycle_control dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .zero       (zero),
        .pc_write   (pc_write),
        .i_or_d     (i_or_d),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .pc_source  (pc_source),
        .state      (state),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    logic [19:0] w_vec;
    assign w_vec = {pc_write, i_or_d, mem_read, mem_write, ir_write, reg_write,
                    reg_dst, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
                    state, illegal};

    // Reference: what every output should be in a given state, straight from the state descriptions
    function automatic logic [19:0] exp_out(input int st, input logic [5:0] op,
                                            input logic z, input logic r);
        logic pcw, iod, mr, mw, irw, rw, rd, m2r, asa, ill;
        logic [1:0] asb, aop, pcs;
        logic [3:0] s4;
        {pcw, iod, mr, mw, irw, rw, rd, m2r, asa, ill} = '0;
        asb = 2'd0; aop = 2'd0; pcs = 2'd0;
        s4  = st[3:0];
        case (st)
            0:  begin mr = 1; irw = 1; pcw = 1; asb = 2'd1; aop = 2'd2; end
            1:  begin asb = 2'd3; aop = 2'd2;
                      ill = !(op inside {6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h08, 6'h0F, 6'h02}); end
            2:  begin asa = 1; asb = 2'd2; aop = 2'd2; end
            3:  begin mr = 1; iod = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mw = 1; iod = 1; end
            6:  begin asa = 1; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 2'd1; pcs = 2'd1;
                      pcw = (op == 6'h04 && z) || (op == 6'h05 && !z); end
            9:  begin asa = 1; asb = 2'd2; aop = 2'd2; end
            10: begin asa = 1; asb = 2'd2; aop = 2'd3; end
            11: begin rw = 1; end
            12: begin pcw = 1; pcs = 2'd2; end
            default: begin end
        endcase
        if (r) begin
            {pcw, mr, mw, irw, rw, ill} = '0;
        end
        return {pcw, iod, mr, mw, irw, rw, rd, m2r, asa, asb, aop, pcs, s4, ill};
    endfunction

    // Reference: state path of one instruction, state k in nibble k
    function automatic logic [19:0] seq_of(input logic [5:0] op, output int len);
        case (op)
            6'h23:        begin len = 5; return {4'd4, 4'd3, 4'd2, 4'd1, 4'd0}; end
            6'h2B:        begin len = 4; return {4'd0, 4'd5, 4'd2, 4'd1, 4'd0}; end
            6'h00:        begin len = 4; return {4'd0, 4'd7, 4'd6, 4'd1, 4'd0}; end
            6'h04, 6'h05: begin len = 3; return {8'd0, 4'd8, 4'd1, 4'd0}; end
            6'h08:        begin len = 4; return {4'd0, 4'd11, 4'd9, 4'd1, 4'd0}; end
            6'h0F:        begin len = 4; return {4'd0, 4'd11, 4'd10, 4'd1, 4'd0}; end
            6'h02:        begin len = 3; return {8'd0, 4'd12, 4'd1, 4'd0}; end
            default:      begin len = 2; return {12'd0, 4'd1, 4'd0}; end
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: drive zero, check all outputs, advance past the next rising edge
    task automatic step(input int st, input logic z, input string tag);
        zero = z;
        #1;
        chk($sformatf("%s_st%0d_outs", tag, st), {12'd0, w_vec}, {12'd0, exp_out(st, opcode, z, rst)});
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [5:0]  op;
        logic        z;
        int          len;
        logic [19:0] states;
    } vec_t;

    vec_t tbl[12];

    initial begin
        logic [19:0] sq;
        int          ln;
        logic [3:0]  want;

        rst = 1'b1; opcode = 6'h00; zero = 1'b0;
        #2;
        chk("reset_outs", {12'd0, w_vec}, {12'd0, exp_out(0, 6'h00, 1'b0, 1'b1)});
        chk("reset_state", {28'd0, state}, 32'd0);
        @(posedge clk); #1;
        chk("reset_strobes", {26'd0, pc_write, mem_read, mem_write, ir_write, reg_write, illegal}, 32'd0);
        rst = 1'b0;

        tbl[0]  = '{6'h00, 1'b0, 4, 20'h07610};
        tbl[1]  = '{6'h23, 1'b0, 5, 20'h43210};
        tbl[2]  = '{6'h2B, 1'b1, 4, 20'h05210};
        tbl[3]  = '{6'h04, 1'b1, 3, 20'h00810};
        tbl[4]  = '{6'h04, 1'b0, 3, 20'h00810};
        tbl[5]  = '{6'h05, 1'b1, 3, 20'h00810};
        tbl[6]  = '{6'h05, 1'b0, 3, 20'h00810};
        tbl[7]  = '{6'h08, 1'b0, 4, 20'h0B910};
        tbl[8]  = '{6'h0F, 1'b0, 4, 20'h0BA10};
        tbl[9]  = '{6'h02, 1'b0, 3, 20'h00C10};
        tbl[10] = '{6'h3F, 1'b0, 2, 20'h00010};
        tbl[11] = '{6'h01, 1'b1, 2, 20'h00010};

        for (int i = 0; i < 12; i++) begin
            opcode = tbl[i].op;
            for (int c = 0; c < tbl[i].len; c++) begin
                sq   = tbl[i].states;
                want = sq[4*c +: 4];
                chk($sformatf("tbl%0d_state%0d", i, c), {28'd0, state}, {28'd0, want});
                step(int'(want), tbl[i].z, $sformatf("tbl%0d", i));
            end
            chk($sformatf("tbl%0d_next_fetch", i), {28'd0, state}, 32'd0);
        end

        // Branch decision must follow zero within the BRANCH cycle
        opcode = 6'h04;
        step(0, 1'b0, "bz"); step(1, 1'b0, "bz");
        zero = 1'b0; #1;
        chk("beq_z0_pcw", {31'd0, pc_write}, 32'd0);
        zero = 1'b1; #1;
        chk("beq_z1_pcw", {31'd0, pc_write}, 32'd1);
        chk("beq_pcsrc", {30'd0, pc_source}, 32'd1);
        @(posedge clk); #1;

        // Reset during MEM_WB of lw abandons the writeback immediately
        opcode = 6'h23;
        step(0, 1'b0, "rlw"); step(1, 1'b0, "rlw"); step(2, 1'b0, "rlw"); step(3, 1'b0, "rlw");
        chk("memwb_state", {28'd0, state}, 32'd4);
        chk("memwb_regwrite", {31'd0, reg_write}, 32'd1);
        #2; rst = 1'b1; #1;
        chk("midrst_state", {28'd0, state}, 32'd0);
        chk("midrst_regwrite", {31'd0, reg_write}, 32'd0);
        @(posedge clk); #1;
        chk("midrst_hold", {26'd0, pc_write, mem_read, mem_write, ir_write, reg_write, illegal}, 32'd0);
        rst = 1'b0;

        // Randomized instruction stream against the path/output reference
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0: opcode = 6'h00;
                1: opcode = 6'h23;
                2: opcode = 6'h2B;
                3: opcode = 6'h04;
                4: opcode = 6'h05;
                5: opcode = 6'h08;
                6: opcode = 6'h0F;
                7: opcode = 6'h02;
                default: opcode = 6'($urandom);
            endcase
            sq = seq_of(opcode, ln);
            for (int c = 0; c < ln; c++) begin
                want = sq[4*c +: 4];
                step(int'(want), 1'($urandom), "rnd");
            end
        end
        chk("rnd_end_fetch", {28'd0, state}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states, and generates the datapath enables and mux selects. It also drives the 2-bit ALUOp that the ALU control decoder combines with funct to select the ALU function.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- opcode  in  6  instr[31:26] from instruction register; stable from DECODE onward
- zero  in  1  ALU zero flag
- pc_write  out  1  PC load enable
- i_or_d  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read strobe
- mem_write  out  1  memory write strobe
- ir_write  out  1  instruction register load
- reg_write  out  1  register file write enable
- reg_dst  out  1  destination select: 0 = rt, 1 = rd
- mem_to_reg  out  1  writeback data select: 0 = ALUOut, 1 = MDR
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = reg A
- alu_src_b  out  2  ALU B select: 00 = reg B, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm<<2
- alu_op  out  2  00 = funct decode, 01 = sub, 10 = add, 11 = function code 6 (lui)
- pc_source  out  2  PC data select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- state  out  4  current state encoding, for debug
- illegal  out  1  one-cycle pulse when an unsupported opcode is decoded

## Operation
- States and encodings:
  - FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4, MEM_WRITE = 5, EXECUTE = 6
  - R_WB = 7, BRANCH = 8, ADDI_EXEC = 9, LUI_EXEC = 10, IMM_WB = 11, JUMP = 12
  - Encodings 13–15 are unused and go to FETCH.
- Opcodes: R = 0x00, lw = 0x23, sw = 0x2B, beq = 0x04, bne = 0x05, addi = 0x08, lui = 0x0F, j = 0x02.
- Outputs are Moore (decoded from state) except pc_write in BRANCH. Every output not listed for a state is 0.
- FETCH: mem_read, ir_write, pc_write = 1; i_or_d = 0; alu_src_a = 0; alu_src_b = 01; alu_op = 10; pc_source = 00. Next state is DECODE.
- DECODE: alu_src_a = 0, alu_src_b = 11, alu_op = 10 (precomputes branch target). Next state by opcode:
  - lw, sw → MEM_ADDR
  - R → EXECUTE
  - beq, bne → BRANCH
  - addi → ADDI_EXEC
  - lui → LUI_EXEC
  - j → JUMP
  - other opcode → FETCH, with illegal = 1 for this cycle
- MEM_ADDR: alu_src_a = 1, alu_src_b = 10, alu_op = 10. Next is MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: mem_read = 1, i_or_d = 1. Next is MEM_WB.
- MEM_WB: reg_write = 1, mem_to_reg = 1, reg_dst = 0. Next is FETCH.
- MEM_WRITE: mem_write = 1, i_or_d = 1. Next is FETCH.
- EXECUTE: alu_src_a = 1, alu_src_b = 00, alu_op = 00. Next is R_WB.
- R_WB: reg_write = 1, reg_dst = 1. Next is FETCH.
- BRANCH: alu_src_a = 1, alu_src_b = 00, alu_op = 01, pc_source = 01. Next is FETCH.
  - pc_write = (opcode == beq & zero) | (opcode == bne & ~zero).
- ADDI_EXEC: alu_src_a = 1, alu_src_b = 10, alu_op = 10. Next is IMM_WB.
- LUI_EXEC: alu_src_a = 1, alu_src_b = 10, alu_op = 11. Next is IMM_WB.
- IMM_WB: reg_write = 1, reg_dst = 0, mem_to_reg = 0. Next is FETCH.
- JUMP: pc_write = 1, pc_source = 10. Next is FETCH.

## Timing
- Reset:
  - rst asserted forces state = FETCH immediately (asynchronous).
  - While rst is high, pc_write, mem_read, mem_write, ir_write, reg_write and illegal are all 0.
  - The first fetch occurs on the first rising edge after rst deasserts.
  - Reset asserted mid-instruction abandons that instruction; no writeback strobe is issued after rst rises.
- Cycles per instruction, counting FETCH:
  - lw: 5
  - R, sw, addi, lui: 4
  - beq, bne, j: 3
  - illegal: 2
- zero is sampled combinationally during BRANCH only; its value in other states has no effect.
- At most one of mem_read and mem_write is high in any cycle.
- ir_write is high only in FETCH.

## Structure
- Shared package `cpu_pkg` holds:
  - state encodings
  - opcode constants
  - ALUOp constants (ALUOP_FUNCT, ALUOP_SUB, ALUOP_ADD, ALUOP_LUI)
  - alu_src_b and pc_source select constants
- ALU control uses the same ALUOp constants from `cpu_pkg`.
- Single module; no sub-modules. Organised as a state register, a next-state case, and an output-decode case.

## Test plan
- Reset, then opcode = 0x00 → states 0, 1, 6, 7, 0. In R_WB: reg_write = 1, reg_dst = 1. In EXECUTE: alu_op = 00.
- opcode = 0x23 → states 0, 1, 2, 3, 4. In MEM_READ: i_or_d = 1, mem_read = 1. In MEM_WB: mem_to_reg = 1. Next fetch at cycle 6.
- opcode = 0x04 with zero = 1 → pc_write = 1, pc_source = 01 in BRANCH. Repeat with zero = 0 → pc_write = 0. For opcode = 0x05, the opposite in both cases.
- opcode = 0x0F → in LUI_EXEC: alu_op = 11, alu_src_b = 10. In IMM_WB: reg_write = 1, reg_dst = 0.
- opcode = 0x3F → illegal pulses for one cycle in DECODE; state returns to 0; no reg_write or mem_write is issued.
- Assert rst during MEM_WB of lw → state = 0 immediately; reg_write drops to 0 within the same cycle.
